fft_stage3_twiddle_mult: RTL and testbench
==========================================

Name: fft_stage3_twiddle_mult

Overview:
Streaming twiddle-multiply stage placed directly after the stage-3 radix-2 butterfly of the 256-point FFT. It tracks each sample's position in the frame and drives the read pointer and enable of the stage-3 twiddle ROM (32-entry, Q1.12). It then multiplies each sample by the returned coefficient (cos_data + j·sin_data, where sin_data already holds −sin θ). The rounded, saturated result feeds stage 4.

Parameters:
N, 256, FFT length (power of 2, 64..256)
SIZE, 8, log2(N); ROM pointer width is SIZE-3
DATA_W, 16, signed sample width (re and im), input and output
TW_W, 14, signed twiddle width
TW_FRAC, 12, twiddle fractional bits (4096 = 1.0)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous reset, active-high
in_valid  in  1  input sample valid
in_sof  in  1  first sample of frame; qualified by in_valid
in_re  in  DATA_W  input real, signed
in_im  in  DATA_W  input imag, signed
rd_ptr_angle  out  SIZE-3  ROM read pointer, combinational
tw_en  out  1  ROM read enable, combinational (= in_valid)
cos_data  in  TW_W  ROM cos, valid 1 cycle after tw_en
sin_data  in  TW_W  ROM −sin, valid 1 cycle after tw_en
out_valid  out  1  output valid
out_sof  out  1  output first-of-frame
out_re  out  DATA_W  product real
out_im  out  DATA_W  product imag
out_ovf  out  1  1-cycle pulse, aligned with out_valid, when re or im saturated

Behaviour:
- Reset (async, active-high) clears: sample counter to 0, all valid/sof pipeline bits, out_valid, out_sof, out_ovf. Also clears out_re and out_im to 0.
- Sample counter cnt (SIZE bits) advances only on in_valid:
  - cnt_eff = 0 if in_sof, else cnt.
  - On in_valid, next cnt = cnt_eff + 1, wrapping from N-1 to 0.
  - in_sof mid-frame restarts the frame. No error is flagged.
- Group position p = cnt_eff mod (N/4); half point H = N/8.
- rd_ptr_angle = 0 when p < H, otherwise p − H. The ROM's own shift scales this for N < 256.
  - Example, N=256: p=40 → index 8 (angle 64π/256).
- tw_en = in_valid. The ROM holds its output when tw_en is low.
- Pipeline, 3-cycle fixed latency. A sample accepted at edge t appears with out_valid at edge t+3. No backpressure; one sample per cycle is sustained.
  - S0 (edge t): ROM registers the coefficient. The block registers in_re, in_im, valid and sof alongside it.
  - S1 (edge t+1): register the four products a·c, b·d, a·d, b·c. Each is DATA_W+TW_W bits, signed.
  - S2 (edge t+2): re = ac − bd, im = ad + bc, each DATA_W+TW_W+1 bits. Add 2^(TW_FRAC−1), arithmetic shift right by TW_FRAC, saturate to DATA_W.
- Output registers on edge t+3. out_ovf = 1 if either component was clipped.
- Index 0 (cos=4096, sin=0) is exact pass-through: round-half-up of an exact value is identity.
- Bubbles (in_valid low) propagate as out_valid low. The data outputs hold their last value.
- Reset asserted mid-frame discards all in-flight samples. The next frame requires in_sof, or starts with the counter at 0.

Decomposition:
- Shared package fft_pkg holds:
  - width constants DATA_W, TW_W, TW_FRAC;
  - function sat_round(value, frac, width) with round-half-up and symmetric clip to [−2^(w−1), 2^(w−1)−1].
- One sub-module, cmult_q12: a 2-stage pipelined signed complex multiplier with rounding and saturation. It is reused by the other stage wrappers.
- The top level holds the counter, address logic, alignment registers and valid/sof delay line.

Test Plan:
- Reset then a single sample at p=5, in=(1234,−567) → rd_ptr_angle=0; 3 cycles later out=(1234,−567), out_valid=1, out_ovf=0.
- p=40 (N=256), in=(1000,0), ROM returns cos=2896, sin=−2896 → rd_ptr_angle=8; out=(707,−707).
- p=63, in=(4096,0), ROM returns cos=−4076, sin=−401 → rd_ptr_angle=31; out=(−4076,−401).
- p=40, in=(−32768,−32768), cos=2896, sin=−2896 → raw re=−46336 saturates to −32768; im=0; out_ovf=1 for exactly one cycle.
- Continuous 256-sample frame with in_sof on the first sample, then a second frame:
  - pointer sequence per 64-group is 0×32, then 0..31;
  - out_sof appears on output samples 0 and 256;
  - out_valid stays high for 512 consecutive cycles.
- in_sof at sample 100, and rst asserted asynchronously mid-frame:
  - in_sof restarts the counter, so sample 100 uses p=0;
  - after rst, out_valid drops to 0 immediately and no stale sample emerges;
  - the next in_sof sample maps to index 0.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared width constants and the round/saturate helper used by the FFT stage wrappers.
package fft_pkg;

  localparam int DATA_W  = 16;
  localparam int TW_W    = 14;
  localparam int TW_FRAC = 12;
  localparam int PROD_W  = DATA_W + TW_W;
  localparam int SUM_W   = DATA_W + TW_W + 1;

  typedef struct packed {
    logic [DATA_W-1:0] value;
    logic              clipped;
  } sat_t;

  // Round half-up by 'frac' bits, then clip symmetrically into a signed 'width'-bit range.
  function automatic sat_t sat_round(input logic signed [SUM_W-1:0] value,
                                     input int frac,
                                     input int width);
    logic signed [SUM_W:0] v_ext;
    logic signed [SUM_W:0] v_half;
    logic signed [SUM_W:0] v_max;
    logic signed [SUM_W:0] v_min;
    sat_t                  res;
    v_ext  = {value[SUM_W-1], value};
    v_half = (SUM_W+1)'(1) << (frac - 1);
    v_ext  = (v_ext + v_half) >>> frac;
    v_max  = (SUM_W+1)'((1 << (width - 1)) - 1);
    v_min  = -v_max - (SUM_W+1)'(1);
    res.clipped = 1'b1;
    if (v_ext > v_max) begin
      res.value = v_max[DATA_W-1:0];
    end else if (v_ext < v_min) begin
      res.value = v_min[DATA_W-1:0];
    end else begin
      res.value   = v_ext[DATA_W-1:0];
      res.clipped = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/cmult_q12.sv
// Two-stage signed complex multiplier (a+jb)(c+jd) with Q1.12 coefficient, rounding and saturation.
module cmult_q12
  import fft_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] i_a,
  input  logic signed [DATA_W-1:0] i_b,
  input  logic signed [TW_W-1:0]   i_c,
  input  logic signed [TW_W-1:0]   i_d,
  output logic [DATA_W-1:0]        o_re,
  output logic [DATA_W-1:0]        o_im,
  output logic                     o_ovf
);

  logic signed [PROD_W-1:0] r_ac;
  logic signed [PROD_W-1:0] r_bd;
  logic signed [PROD_W-1:0] r_ad;
  logic signed [PROD_W-1:0] r_bc;
  logic signed [SUM_W-1:0]  w_re_sum;
  logic signed [SUM_W-1:0]  w_im_sum;
  sat_t                     w_re_sat;
  sat_t                     w_im_sat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ac <= '0;
      r_bd <= '0;
      r_ad <= '0;
      r_bc <= '0;
    end else begin
      r_ac <= PROD_W'(i_a) * PROD_W'(i_c);
      r_bd <= PROD_W'(i_b) * PROD_W'(i_d);
      r_ad <= PROD_W'(i_a) * PROD_W'(i_d);
      r_bc <= PROD_W'(i_b) * PROD_W'(i_c);
    end
  end

  assign w_re_sum = SUM_W'(r_ac) - SUM_W'(r_bd);
  assign w_im_sum = SUM_W'(r_ad) + SUM_W'(r_bc);
  assign w_re_sat = sat_round(w_re_sum, TW_FRAC, DATA_W);
  assign w_im_sat = sat_round(w_im_sum, TW_FRAC, DATA_W);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_re  <= '0;
      o_im  <= '0;
      o_ovf <= 1'b0;
    end else begin
      o_re  <= w_re_sat.value;
      o_im  <= w_im_sat.value;
      o_ovf <= w_re_sat.clipped | w_im_sat.clipped;
    end
  end

endmodule

// File: rtl/fft_stage3_twiddle_mult.sv
// Stage-3 twiddle multiply: frame position tracking, twiddle ROM addressing and a 3-cycle complex multiply.
module fft_stage3_twiddle_mult
  import fft_pkg::*;
#(
  parameter int N    = 256,
  parameter int SIZE = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_sof,
  input  logic [DATA_W-1:0] in_re,
  input  logic [DATA_W-1:0] in_im,
  output logic [SIZE-4:0]   rd_ptr_angle,
  output logic              tw_en,
  input  logic [TW_W-1:0]   cos_data,
  input  logic [TW_W-1:0]   sin_data,
  output logic              out_valid,
  output logic              out_sof,
  output logic [DATA_W-1:0] out_re,
  output logic [DATA_W-1:0] out_im,
  output logic              out_ovf
);

  logic [SIZE-1:0]   r_cnt;
  logic [SIZE-1:0]   w_cnt_eff;
  logic [SIZE-3:0]   w_pos;
  logic [DATA_W-1:0] r_re_s0;
  logic [DATA_W-1:0] r_im_s0;
  logic [2:0]        r_valid_pipe;
  logic [2:0]        r_sof_pipe;
  logic [DATA_W-1:0] w_re;
  logic [DATA_W-1:0] w_im;
  logic              w_ovf;

  assign w_cnt_eff = (in_valid && in_sof) ? '0 : r_cnt;
  // Position within a quarter frame; the first half of each group uses twiddle index 0.
  assign w_pos        = w_cnt_eff[SIZE-3:0];
  assign rd_ptr_angle = w_pos[SIZE-3] ? w_pos[SIZE-4:0] : '0;
  assign tw_en        = in_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (in_valid) begin
      r_cnt <= (w_cnt_eff == SIZE'(N - 1)) ? '0 : w_cnt_eff + SIZE'(1);
    end
  end

  // Sample is registered on the same edge the ROM registers its coefficient.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_re_s0      <= '0;
      r_im_s0      <= '0;
      r_valid_pipe <= '0;
      r_sof_pipe   <= '0;
    end else begin
      if (in_valid) begin
        r_re_s0 <= in_re;
        r_im_s0 <= in_im;
      end
      r_valid_pipe <= {r_valid_pipe[1:0], in_valid};
      r_sof_pipe   <= {r_sof_pipe[1:0], in_valid & in_sof};
    end
  end

  cmult_q12 u_cmult (
    .clk   (clk),
    .rst   (rst),
    .i_a   (r_re_s0),
    .i_b   (r_im_s0),
    .i_c   (cos_data),
    .i_d   (sin_data),
    .o_re  (w_re),
    .o_im  (w_im),
    .o_ovf (w_ovf)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_ovf   <= 1'b0;
      out_re    <= '0;
      out_im    <= '0;
    end else begin
      out_valid <= r_valid_pipe[2];
      out_sof   <= r_sof_pipe[2];
      out_ovf   <= r_valid_pipe[2] & w_ovf;
      if (r_valid_pipe[2]) begin
        out_re <= w_re;
        out_im <= w_im;
      end
    end
  end

endmodule

// File: tb/tb_fft_stage3_twiddle_mult.sv
// Directed bench for fft_stage3_twiddle_mult with a frame-position / complex-arithmetic reference model.
module tb_fft_stage3_twiddle_mult;

  localparam int DEPTH = 4096;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_sof = 1'b0;
  logic [15:0] in_re = '0;
  logic [15:0] in_im = '0;
  logic [4:0]  rd_ptr_angle;
  logic        tw_en;
  logic [13:0] cos_data = '0;
  logic [13:0] sin_data = '0;
  logic        out_valid;
  logic        out_sof;
  logic [15:0] out_re;
  logic [15:0] out_im;
  logic        out_ovf;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int pos = 0;
  int exp_ptr_now = 0;
  int hold_re = 0;
  int hold_im = 0;
  int tab_cos[32];
  int tab_sin[32];
  bit exp_valid[DEPTH];
  bit exp_sof[DEPTH];
  bit exp_ovf[DEPTH];
  int exp_re[DEPTH];
  int exp_im[DEPTH];
  bit pin_en[DEPTH];
  bit pin_ovf[DEPTH];
  int pin_re[DEPTH];
  int pin_im[DEPTH];

  fft_stage3_twiddle_mult dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_sof       (in_sof),
    .in_re        (in_re),
    .in_im        (in_im),
    .rd_ptr_angle (rd_ptr_angle),
    .tw_en        (tw_en),
    .cos_data     (cos_data),
    .sin_data     (sin_data),
    .out_valid    (out_valid),
    .out_sof      (out_sof),
    .out_re       (out_re),
    .out_im       (out_im),
    .out_ovf      (out_ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Twiddle ROM: one cycle read latency, holds output when not enabled.
  always @(posedge clk) begin
    if (tw_en) begin
      cos_data <= 14'(tab_cos[rd_ptr_angle]);
      sin_data <= 14'(tab_sin[rd_ptr_angle]);
    end
  end

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int clip16(input real x);
    if (x > 32767.0) return 32767;
    if (x < -32768.0) return -32768;
    return $rtoi(x);
  endfunction

  function automatic void model_mult(input int a, input int b, input int c, input int d,
                                     output int re, output int im, output bit ovf);
    real rr;
    real ri;
    rr  = $floor(real'(a * c - b * d) / 4096.0 + 0.5);
    ri  = $floor(real'(a * d + b * c) / 4096.0 + 0.5);
    ovf = (rr > 32767.0) || (rr < -32768.0) || (ri > 32767.0) || (ri < -32768.0);
    re  = clip16(rr);
    im  = clip16(ri);
  endfunction

  // Drive one cycle of input (called just after a rising edge) and record what must emerge 3 edges later.
  task automatic send(input bit v, input bit s, input int re, input int im, input int lit_ptr);
    int idx;
    int p;
    int ptr;
    int er;
    int ei;
    bit eo;
    in_valid = v;
    in_sof   = s;
    in_re    = 16'(re);
    in_im    = 16'(im);
    idx = (cyc + 4) % DEPTH;
    exp_valid[idx] = v;
    exp_sof[idx]   = 1'b0;
    exp_ovf[idx]   = 1'b0;
    if (v) begin
      if (s) pos = 0;
      p   = pos % 64;
      ptr = (p < 32) ? 0 : p - 32;
      exp_ptr_now = ptr;
      model_mult(re, im, tab_cos[ptr], tab_sin[ptr], er, ei, eo);
      exp_re[idx]  = er;
      exp_im[idx]  = ei;
      exp_sof[idx] = s;
      exp_ovf[idx] = eo;
      pos = (pos + 1) % 256;
    end
    if (lit_ptr >= 0) begin
      #1;
      check("rd_ptr_literal", int'(rd_ptr_angle), lit_ptr);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic pin_out(input int re, input int im, input bit ovf);
    int idx;
    idx = (cyc + 4) % DEPTH;
    pin_en[idx]  = 1'b1;
    pin_re[idx]  = re;
    pin_im[idx]  = im;
    pin_ovf[idx] = ovf;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send(1'b0, 1'b0, 0, 0, -1);
  endtask

  task automatic run_to(input int p);
    for (int i = 0; i < p; i++) send(1'b1, i == 0, 0, 0, -1);
  endtask

  always @(negedge clk) begin
    int k;
    k = cyc % DEPTH;
    if (rst) begin
      hold_re = 0;
      hold_im = 0;
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_out_sof", int'(out_sof), 0);
      check("rst_out_ovf", int'(out_ovf), 0);
      check("rst_out_re", int'($signed(out_re)), 0);
      check("rst_out_im", int'($signed(out_im)), 0);
    end else begin
      check("tw_en", int'(tw_en), int'(in_valid));
      if (in_valid) check("rd_ptr", int'(rd_ptr_angle), exp_ptr_now);
      check("out_valid", int'(out_valid), int'(exp_valid[k]));
      check("out_sof", int'(out_sof), exp_valid[k] ? int'(exp_sof[k]) : 0);
      check("out_ovf", int'(out_ovf), exp_valid[k] ? int'(exp_ovf[k]) : 0);
      if (exp_valid[k]) begin
        hold_re = exp_re[k];
        hold_im = exp_im[k];
        $display("out cyc=%0d re=%0d im=%0d sof=%0b ovf=%0b", cyc,
                 $signed(out_re), $signed(out_im), out_sof, out_ovf);
      end
      check("out_re", int'($signed(out_re)), hold_re);
      check("out_im", int'($signed(out_im)), hold_im);
      if (pin_en[k]) begin
        check("pin_valid", int'(out_valid), 1);
        check("pin_re", int'($signed(out_re)), pin_re[k]);
        check("pin_im", int'($signed(out_im)), pin_im[k]);
        check("pin_ovf", int'(out_ovf), int'(pin_ovf[k]));
        pin_en[k] = 1'b0;
      end
    end
  end

  initial begin
    for (int k = 0; k < 32; k++) begin
      real th;
      th = 3.14159265358979 * real'(k) / 32.0;
      tab_cos[k] = $rtoi($floor($cos(th) * 4096.0 + 0.5));
      tab_sin[k] = $rtoi($floor(-$sin(th) * 4096.0 + 0.5));
    end
    check("tab_cos0", tab_cos[0], 4096);
    check("tab_cos8", tab_cos[8], 2896);
    check("tab_sin8", tab_sin[8], -2896);
    check("tab_cos31", tab_cos[31], -4076);
    check("tab_sin31", tab_sin[31], -401);

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Index 0 pass-through at p=5
    run_to(5);
    pin_out(1234, -567, 1'b0);
    send(1'b1, 1'b0, 1234, -567, 0);
    idle(5);

    // p=40 -> index 8
    run_to(40);
    pin_out(707, -707, 1'b0);
    send(1'b1, 1'b0, 1000, 0, 8);
    idle(3);

    // Saturation at p=40, followed immediately by an unclipped sample
    run_to(40);
    pin_out(-32768, 0, 1'b1);
    send(1'b1, 1'b0, -32768, -32768, 8);
    send(1'b1, 1'b0, 100, 100, 9);
    idle(4);

    // p=63 -> index 31
    run_to(63);
    pin_out(-4076, -401, 1'b0);
    send(1'b1, 1'b0, 4096, 0, 31);
    idle(3);

    // Two back-to-back frames
    for (int i = 0; i < 512; i++) begin
      send(1'b1, (i % 256) == 0, ((i * 1237) % 65536) - 32768,
           ((i * 4099 + 777) % 65536) - 32768, (i % 64 == 40) ? 8 : -1);
    end
    idle(4);

    // Mid-frame in_sof restart at sample 100
    for (int i = 0; i < 100; i++) send(1'b1, i == 0, i * 50 - 2000, 3000 - i * 7, -1);
    send(1'b1, 1'b1, 7777, -1111, 0);
    for (int j = 1; j <= 45; j++) send(1'b1, 1'b0, j * 300, -j * 200, (j == 40) ? 8 : -1);

    // Asynchronous reset with samples still in flight
    in_valid = 1'b0;
    in_sof   = 1'b0;
    #2 rst = 1'b1;
    #1 check("rst_async_valid", int'(out_valid), 0);
    for (int i = 0; i < 9; i++) begin
      exp_valid[(cyc + i) % DEPTH] = 1'b0;
      pin_en[(cyc + i) % DEPTH]    = 1'b0;
    end
    pos = 0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    idle(5);

    // Counter restarts at 0 without in_sof, then an explicit frame start
    for (int j = 0; j < 35; j++) begin
      send(1'b1, 1'b0, 1000 - j * 60, j * 90, (j == 0) ? 0 : ((j == 34) ? 2 : -1));
    end
    send(1'b1, 1'b1, 500, -500, 0);
    idle(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
